// File: rtl/svc_rv_btb_if.sv
// svc_rv_btb_if: lookup/update bundle between fetch/execute and the branch target buffer
interface svc_rv_btb_if #(parameter int XLEN = 32);
  logic ready;
  logic lookup_en;
  logic [XLEN-1:0] lookup_pc;
  logic lookup_hit;
  logic lookup_taken;
  logic [XLEN-1:0] lookup_target;
  logic lookup_is_return;
  logic update_en;
  logic [XLEN-1:0] update_pc;
  logic [XLEN-1:0] update_target;
  logic update_taken;
  logic update_is_return;
  modport master (
    input ready, lookup_hit, lookup_taken, lookup_target, lookup_is_return,
    output lookup_en, lookup_pc, update_en, update_pc, update_target, update_taken, update_is_return
  );
  modport slave (
    output ready, lookup_hit, lookup_taken, lookup_target, lookup_is_return,
    input lookup_en, lookup_pc, update_en, update_pc, update_target, update_taken, update_is_return
  );
endinterface

// File: rtl/svc_rv_btb.sv
// svc_rv_btb: direct-mapped BTB with 2-bit counters and a post-reset valid sweep.
// Define SVC_RV_BTB_BYPASS_EN to forward a same-cycle same-index update into the lookup.
module svc_rv_btb #(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16
) (
  input logic clk,
  input logic rst_n,
  svc_rv_btb_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic ready_q, ready_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d, ret_q, ret_d;
  logic [TAG_W-1:0] tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_d [BTB_ENTRIES];
  logic [XLEN-1:0] tgt_q [BTB_ENTRIES];
  logic [XLEN-1:0] tgt_d [BTB_ENTRIES];
  logic [1:0] ctr_q [BTB_ENTRIES];
  logic [1:0] ctr_d [BTB_ENTRIES];
  logic hit_q, hit_d, taken_q, taken_d, isret_q, isret_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [IDX_W-1:0] u_idx, l_idx;
  logic [TAG_W-1:0] u_tag, l_tag, rd_tag;
  logic run, u_hit, l_hit, rd_valid, rd_ctr1, rd_ret;
  logic [XLEN-1:0] rd_tgt;
  logic unused_pc_lsb;
  assign run = state_q == RUN;
  assign u_idx = bus.update_pc[IDX_W+1:2];
  assign u_tag = bus.update_pc[XLEN-1:IDX_W+2];
  assign l_idx = bus.lookup_pc[IDX_W+1:2];
  assign l_tag = bus.lookup_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsb = ^{bus.update_pc[1:0], bus.lookup_pc[1:0]};
  assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready_d = ready_q;
    valid_d = valid_q;
    ret_d = ret_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    if (!run) begin
      valid_d[sweep_q] = 1'b0;
      sweep_d = sweep_q + 1'b1;
      state_d = sweep_q == IDX_W'(BTB_ENTRIES - 1) ? RUN : INIT;
      ready_d = sweep_q == IDX_W'(BTB_ENTRIES - 1);
    end else if (bus.update_en && u_hit) begin
      ctr_d[u_idx] = bus.update_taken ? (ctr_q[u_idx] == 2'd3 ? 2'd3 : ctr_q[u_idx] + 2'd1)
                                      : (ctr_q[u_idx] == 2'd0 ? 2'd0 : ctr_q[u_idx] - 2'd1);
      tgt_d[u_idx] = bus.update_taken ? bus.update_target : tgt_q[u_idx];
      ret_d[u_idx] = bus.update_is_return;
    end else if (bus.update_en && bus.update_taken) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx] = u_tag;
      tgt_d[u_idx] = bus.update_target;
      ctr_d[u_idx] = 2'b10;
      ret_d[u_idx] = bus.update_is_return;
    end
  end
  // Forwarding reads the next-state arrays; the default reads the stored state.
`ifdef SVC_RV_BTB_BYPASS_EN
  assign rd_valid = valid_d[l_idx];
  assign rd_tag = tag_d[l_idx];
  assign rd_tgt = tgt_d[l_idx];
  assign rd_ctr1 = ctr_d[l_idx][1];
  assign rd_ret = ret_d[l_idx];
`else
  assign rd_valid = valid_q[l_idx];
  assign rd_tag = tag_q[l_idx];
  assign rd_tgt = tgt_q[l_idx];
  assign rd_ctr1 = ctr_q[l_idx][1];
  assign rd_ret = ret_q[l_idx];
`endif
  assign l_hit = run && rd_valid && rd_tag == l_tag;
  always_comb begin
    hit_d = bus.lookup_en ? l_hit : hit_q;
    taken_d = bus.lookup_en ? l_hit && rd_ctr1 : taken_q;
    isret_d = bus.lookup_en ? l_hit && rd_ret : isret_q;
    target_d = bus.lookup_en ? (l_hit ? rd_tgt : '0) : target_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
      hit_q <= 1'b0;
      taken_q <= 1'b0;
      isret_q <= 1'b0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
      hit_q <= hit_d;
      taken_q <= taken_d;
      isret_q <= isret_d;
      target_q <= target_d;
      valid_q <= valid_d;
      ret_q <= ret_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      ctr_q <= ctr_d;
    end
  end
  assign bus.ready = ready_q;
  assign bus.lookup_hit = hit_q;
  assign bus.lookup_taken = taken_q;
  assign bus.lookup_target = target_q;
  assign bus.lookup_is_return = isret_q;
endmodule

// File: tb/tb_svc_rv_btb.sv
// tb_svc_rv_btb: table-driven vectors with a lookup scoreboard, plus reset/bypass/hold sequences.
module tb_svc_rv_btb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  svc_rv_btb_if #(.XLEN(32)) bus();
  svc_rv_btb #(.XLEN(32), .BTB_ENTRIES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic ue; logic [31:0] upc; logic [31:0] utgt; logic ut; logic ur;
    logic le; logic [31:0] lpc; logic eh; logic et; logic [31:0] etg; logic er;
  } vec_t;
  typedef struct {
    string name; logic hit; logic taken; logic [31:0] tgt; logic ret;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[$];
  function automatic vec_t upd(logic [31:0] pc, logic [31:0] tgt, logic t, logic r);
    return '{1'b1, pc, tgt, t, r, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
  endfunction
  function automatic vec_t lk(logic [31:0] pc, logic h, logic t, logic [31:0] tg, logic r);
    return '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, pc, h, t, tg, r};
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(string n, logic h, logic t, logic [31:0] tg, logic r);
    exp_t e;
    e = '{n, h, t, tg, r};
    sb.push_back(e);
  endtask
  task automatic drive(vec_t v, string n);
    bus.update_en = v.ue;
    bus.update_pc = v.upc;
    bus.update_target = v.utgt;
    bus.update_taken = v.ut;
    bus.update_is_return = v.ur;
    bus.lookup_en = v.le;
    bus.lookup_pc = v.lpc;
    if (v.le) push(n, v.eh, v.et, v.etg, v.er);
  endtask
  task automatic idle();
    bus.update_en = 1'b0;
    bus.lookup_en = 1'b0;
  endtask
  task automatic chk_out(string n, logic h, logic t, logic [31:0] tg, logic r);
    chk({n, ".hit"}, 32'(bus.lookup_hit), 32'(h));
    chk({n, ".taken"}, 32'(bus.lookup_taken), 32'(t));
    chk({n, ".target"}, bus.lookup_target, tg);
    chk({n, ".ret"}, 32'(bus.lookup_is_return), 32'(r));
  endtask
  // Scoreboard: every lookup accepted at an edge is compared 1 time unit later.
  always @(posedge clk) begin
    if (rst_n && bus.lookup_en) begin
      #1;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: got lookup with no expectation expected queued entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_out(e.name, e.hit, e.taken, e.tgt, e.ret);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t v;
    idle();
    bus.lookup_pc = '0;
    bus.update_pc = '0;
    bus.update_target = '0;
    bus.update_taken = 1'b0;
    bus.update_is_return = 1'b0;
    repeat (3) step();
    chk("rst.ready", 32'(bus.ready), 32'd0);
    chk_out("rst", 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("sweep%0d.ready", k), 32'(bus.ready), 32'(k == 16));
    end
    tbl.push_back(lk(32'h100, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(upd(32'h100, 32'h200, 1'b1, 1'b0));
    tbl.push_back(lk(32'h100, 1'b1, 1'b1, 32'h200, 1'b0));
    tbl.push_back(upd(32'h100, 32'h999, 1'b0, 1'b0));
    tbl.push_back(lk(32'h100, 1'b1, 1'b0, 32'h200, 1'b0));
    tbl.push_back(upd(32'h100, 32'h999, 1'b0, 1'b0));
    tbl.push_back(upd(32'h100, 32'h999, 1'b0, 1'b0));
    tbl.push_back(lk(32'h100, 1'b1, 1'b0, 32'h200, 1'b0));
    tbl.push_back(upd(32'h100, 32'h204, 1'b1, 1'b0));
    tbl.push_back(lk(32'h100, 1'b1, 1'b0, 32'h204, 1'b0));
    tbl.push_back(upd(32'h100, 32'h204, 1'b1, 1'b0));
    tbl.push_back(upd(32'h100, 32'h204, 1'b1, 1'b0));
    tbl.push_back(upd(32'h100, 32'h204, 1'b1, 1'b0));
    tbl.push_back(lk(32'h100, 1'b1, 1'b1, 32'h204, 1'b0));
    tbl.push_back(upd(32'h100, 32'h999, 1'b0, 1'b0));
    tbl.push_back(lk(32'h100, 1'b1, 1'b1, 32'h204, 1'b0));
    tbl.push_back(upd(32'h100, 32'h999, 1'b0, 1'b0));
    tbl.push_back(lk(32'h100, 1'b1, 1'b0, 32'h204, 1'b0));
    tbl.push_back(upd(32'h140, 32'h500, 1'b1, 1'b0));
    tbl.push_back(lk(32'h100, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(lk(32'h140, 1'b1, 1'b1, 32'h500, 1'b0));
    tbl.push_back(upd(32'h180, 32'h800, 1'b0, 1'b0));
    tbl.push_back(lk(32'h180, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(lk(32'h140, 1'b1, 1'b1, 32'h500, 1'b0));
    v = lk(32'h140, 1'b1, 1'b1, 32'h500, 1'b0);
    v.ue = 1'b1; v.upc = 32'h104; v.utgt = 32'h600; v.ut = 1'b1; v.ur = 1'b1;
    tbl.push_back(v);
    tbl.push_back(lk(32'h104, 1'b1, 1'b1, 32'h600, 1'b1));
    tbl.push_back(upd(32'h104, 32'h604, 1'b1, 1'b0));
    tbl.push_back(lk(32'h104, 1'b1, 1'b1, 32'h604, 1'b0));
    tbl.push_back(lk(32'h107, 1'b1, 1'b1, 32'h604, 1'b0));
    foreach (tbl[i]) begin
      drive(tbl[i], $sformatf("vec%0d", i));
      step();
    end
    idle();
    step();
    v = lk(32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    v.ue = 1'b1; v.upc = 32'h300; v.utgt = 32'h700; v.ut = 1'b1; v.ur = 1'b1;
`ifdef SVC_RV_BTB_BYPASS_EN
    v.eh = 1'b1; v.et = 1'b1; v.etg = 32'h700; v.er = 1'b1;
`endif
    drive(v, "bypass");
    step();
    drive(lk(32'h300, 1'b1, 1'b1, 32'h700, 1'b1), "after_bypass");
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("hold%0d", k), 1'b1, 1'b1, 32'h700, 1'b1);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_out("rst2", 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (7) step();
    chk("mid.ready", 32'(bus.ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 10) begin
        v = lk(32'h104, 1'b0, 1'b0, 32'h0, 1'b0);
        v.ue = 1'b1; v.upc = 32'h41C; v.utgt = 32'hA00; v.ut = 1'b1;
        drive(v, "init_lookup");
      end
      step();
      idle();
      chk($sformatf("resweep%0d.ready", k), 32'(bus.ready), 32'(k == 16));
    end
    tbl.delete();
    tbl.push_back(lk(32'h41C, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(lk(32'h104, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(lk(32'h300, 1'b0, 1'b0, 32'h0, 1'b0));
    foreach (tbl[i]) begin
      drive(tbl[i], $sformatf("post%0d", i));
      step();
    end
    idle();
    step();
    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
